// File: rtl/sort4_pkg.sv
// Shared constants and types for the 4-entry sequential sorter.
package sort4_pkg;

  localparam int W     = 5;
  localparam int DEPTH = 4;

  localparam logic [1:0] R_EQ = 2'b00;
  localparam logic [1:0] R_LT = 2'b01;
  localparam logic [1:0] R_GT = 2'b10;

  typedef enum logic [1:0] {
    LOAD,
    SORT,
    DRAIN
  } state_t;

endpackage

// File: rtl/sort4_seq_if.sv
// Valid/ready input and output streams of the sorter.
interface sort4_seq_if;
  import sort4_pkg::*;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/sort4_seq_cmp5.sv
// Combinational unsigned magnitude comparator producing a 2-bit result code.
module cmp5
  import sort4_pkg::*;
#(
  parameter int W = 5
) (
  output logic [1:0]   r,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b
);

  always_comb begin
    r = R_EQ;
    if (a < b) begin
      r = R_LT;
    end else if (a > b) begin
      r = R_GT;
    end
  end

endmodule

// File: rtl/sort4_seq.sv
// Loads four values, bubble-sorts them in place with one shared comparator
// (one compare per cycle, early exit), then streams them out smallest first.
module sort4_seq
  import sort4_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  sort4_seq_if.slave   io,
  output logic         busy,
  output logic [2:0]   swap_cnt
);

  state_t       state_q;
  logic [W-1:0] mem_q [DEPTH];
  logic [1:0]   ld_cnt_q;
  logic [1:0]   rd_cnt_q;
  logic [1:0]   j_q;
  logic [1:0]   limit_q;
  logic         pass_swap_q;
  logic [2:0]   swap_cnt_q;

  logic [1:0]   j_nxt;
  logic [1:0]   cmp_r;
  logic         gt;

  assign j_nxt = j_q + 2'd1;

  cmp5 #(.W(W)) u_cmp (
    .r (cmp_r),
    .a (mem_q[j_q]),
    .b (mem_q[j_nxt])
  );

  assign gt = (cmp_r == R_GT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      ld_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      j_q         <= '0;
      limit_q     <= '0;
      pass_swap_q <= 1'b0;
      swap_cnt_q  <= '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (io.in_valid) begin
            mem_q[ld_cnt_q] <= io.in_data;
            ld_cnt_q        <= ld_cnt_q + 2'd1;
            if (ld_cnt_q == 2'd3) begin
              state_q     <= SORT;
              swap_cnt_q  <= '0;
              j_q         <= '0;
              pass_swap_q <= 1'b0;
              limit_q     <= 2'd3;
            end
          end
        end
        SORT: begin
          if (gt) begin
            mem_q[j_q]   <= mem_q[j_nxt];
            mem_q[j_nxt] <= mem_q[j_q];
            swap_cnt_q   <= swap_cnt_q + 3'd1;
            pass_swap_q  <= 1'b1;
          end
          if (j_q != limit_q - 2'd1) begin
            j_q <= j_nxt;
          end else if (!(pass_swap_q || gt) || limit_q == 2'd1) begin
            state_q <= DRAIN;
          end else begin
            // a swap this pass means the shorter prefix may still be unsorted
            limit_q     <= limit_q - 2'd1;
            j_q         <= '0;
            pass_swap_q <= 1'b0;
          end
        end
        DRAIN: begin
          if (io.out_ready) begin
            rd_cnt_q <= rd_cnt_q + 2'd1;
            if (rd_cnt_q == 2'd3) begin
              state_q  <= LOAD;
              ld_cnt_q <= '0;
            end
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  assign io.in_ready  = (state_q == LOAD);
  assign io.out_valid = (state_q == DRAIN);
  assign io.out_data  = mem_q[rd_cnt_q];
  assign busy         = (state_q != LOAD);
  assign swap_cnt     = swap_cnt_q;

endmodule

// File: tb/tb_sort4_seq.sv
// Randomized scoreboard bench for sort4_seq with a rank/inversion reference model.
module tb_sort4_seq;

  logic       clk;
  logic       rst;
  logic       busy;
  logic [2:0] swap_cnt;

  sort4_seq_if bus ();

  sort4_seq dut (
    .clk      (clk),
    .rst      (rst),
    .io       (bus.slave),
    .busy     (busy),
    .swap_cnt (swap_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [4:0] exp_data_q [$];
  int         exp_swap_q [$];
  int         exp_n_q    [$];

  logic [4:0] vec [4];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: stable rank placement, inversion count for swaps, and the
  // largest "greater elements before me" count for the number of swapping passes.
  task automatic push_expect();
    logic [4:0] srt [4];
    int inv, p, cnt, rank, n;
    inv = 0;
    p   = 0;
    for (int i = 0; i < 4; i++) begin
      rank = 0;
      for (int k = 0; k < 4; k++)
        if (vec[k] < vec[i] || (vec[k] == vec[i] && k < i)) rank++;
      srt[rank] = vec[i];
    end
    for (int k = 0; k < 4; k++) begin
      cnt = 0;
      for (int i = 0; i < k; i++) if (vec[i] > vec[k]) cnt++;
      inv += cnt;
      if (cnt > p) p = cnt;
    end
    n = (p == 0) ? 3 : (p == 1) ? 5 : 6;
    for (int i = 0; i < 4; i++) exp_data_q.push_back(srt[i]);
    exp_swap_q.push_back(inv);
    exp_n_q.push_back(n);
  endtask

  // Monitor
  int         ld_seen   = 0;
  bit         rise_pend = 0;
  int         rise_exp  = 0;
  bit         prev_ov   = 0;
  bit         prev_stall = 0;
  logic [4:0] prev_data = '0;

  always @(negedge clk) begin
    if (rst) begin
      ld_seen    = 0;
      rise_pend  = 0;
      prev_ov    = 0;
      prev_stall = 0;
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        ld_seen++;
        if (ld_seen == 4) begin
          ld_seen = 0;
          if (exp_n_q.size() > 0) begin
            rise_exp  = cyc + exp_n_q.pop_front() + 1;
            rise_pend = 1;
          end
        end
      end
      if (bus.out_valid && !prev_ov) begin
        if (rise_pend) chk("out_valid_rise_cycle", cyc, rise_exp);
        rise_pend = 0;
        if (exp_swap_q.size() > 0) chk("swap_cnt", swap_cnt, exp_swap_q.pop_front());
      end
      if (prev_stall && bus.out_valid) chk("out_data_stall_hold", bus.out_data, prev_data);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_data_q.size() > 0) chk("out_data", bus.out_data, exp_data_q.pop_front());
        else chk("unexpected_output", 1, 0);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_ov    = bus.out_valid;
    end
  end

  task automatic check_reset_values();
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_swap_cnt", swap_cnt, 0);
  endtask

  task automatic load_vec();
    int tries;
    for (int i = 0; i < 4; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = vec[i];
      tries = 0;
      @(negedge clk);
      while (!bus.in_ready && tries < 50) begin
        tries++;
        @(negedge clk);
      end
      if (!bus.in_ready) chk("load_timeout", 0, 1);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  // mode 0: full rate, 1: random out_ready, 2: 5-cycle stall then toggle
  task automatic drain(input int mode);
    int got, guard, stall_cnt;
    got = 0; guard = 0; stall_cnt = 0;
    while (got < 4 && guard < 300) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_data  = 5'($urandom_range(0, 31));
      case (mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = (stall_cnt < 5) ? 1'b0 : ~bus.out_ready;
      endcase
      @(negedge clk);
      chk("in_ready_low_while_busy", bus.in_ready, 0);
      chk("busy_high", busy, 1);
      if (bus.out_valid && !bus.out_ready) stall_cnt++;
      if (bus.out_valid && bus.out_ready) got++;
      @(posedge clk); #1;
      guard++;
    end
    if (got < 4) chk("drain_timeout", got, 4);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("in_ready_after_drain", bus.in_ready, 1);
    chk("scoreboard_empty", exp_data_q.size(), 0);
  endtask

  task automatic run_vec(input int a, input int b, input int c, input int d, input int mode);
    vec[0] = 5'(a); vec[1] = 5'(b); vec[2] = 5'(c); vec[3] = 5'(d);
    push_expect();
    load_vec();
    drain(mode);
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    rst = 1'b0;
    @(posedge clk); #1;

    run_vec(6, 8, 9, 0, 0);
    run_vec(0, 1, 2, 3, 0);
    run_vec(31, 16, 1, 0, 1);
    run_vec(9, 9, 9, 9, 0);
    run_vec(6, 8, 9, 0, 2);

    // reset during the second SORT cycle discards the load
    vec[0] = 5'd6; vec[1] = 5'd8; vec[2] = 5'd9; vec[3] = 5'd0;
    load_vec();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_values();
    run_vec(3, 2, 1, 0, 1);

    for (int t = 0; t < 20; t++) begin
      if ($urandom_range(0, 3) == 0)
        run_vec($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 2));
      else
        run_vec($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                $urandom_range(0, 31), $urandom_range(0, 2));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("final_swap_queue_empty", exp_swap_q.size(), 0);
    chk("final_n_queue_empty", exp_n_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
